spi_master_seq: RTL and testbench
=================================

Name: spi_master_seq

Overview:
- Command-driven SPI master that sequences 11-bit frames into the SPI slave + RAM wrapper (MOSI/SS_n/MISO).
- A single-clock system-side requester issues one command at a time: write address, write data, read address or read data. For read data, the block also captures the 8-bit MISO reply.
- The SPI slave samples on the same clk, so one MOSI bit is driven per clk cycle.

Parameters:
TURNAROUND, 2, cycles between last MOSI bit and first MISO sample for read-data frames (legal 1..15)
GAP, 1, minimum SS_n-high cycles between frames (legal 1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
cmd_data  in  8  payload (ignored content for op 11, still shifted)
rsp_valid  out  1  one-cycle pulse, rsp_data valid
rsp_data  out  8  byte captured from MISO, MSB first
frame_done  out  1  one-cycle pulse when any frame ends (SS_n rises)
busy  out  1  high whenever state != IDLE
SS_n  out  1  slave select, active-low
MOSI  out  1  serial data to slave
MISO  in  1  serial data from slave

Behaviour:
- Reset values: SS_n=1, MOSI=0, cmd_ready=0 during the rst cycle, rsp_valid=0, rsp_data=8'h00, frame_done=0, busy=0, state=IDLE, counters=0.
- Handshake: cmd_ready = (state==IDLE) && !rst. Accept on cmd_valid && cmd_ready, which latches cmd_op/cmd_data into shift register sr[10:0] = {cmd_op[1], cmd_op, cmd_data}. No queueing; cmd_valid while busy is ignored.
- State machine:
  - IDLE: SS_n=1, MOSI=0. On accept -> START.
  - START (1 cycle): SS_n=0, MOSI=0 -> SHIFT.
  - SHIFT (11 cycles): SS_n=0, MOSI=sr[10], shift left each cycle, bit counter 0..10. After bit 10: -> TURN if op==11, else -> END.
  - TURN (TURNAROUND cycles): SS_n=0, MOSI=0 -> RECV.
  - RECV (8 cycles): SS_n=0, MOSI=0. Each rising edge: rx={rx[6:0],MISO}. After the 8th sample, rsp_data<=rx and rsp_valid=1 for exactly one cycle, coincident with entering END.
  - END (GAP cycles): SS_n=1, MOSI=0. frame_done=1 on first END cycle only. After GAP cycles -> IDLE.
- SS_n low duration:
  - ops 00/01/10: exactly 12 cycles.
  - op 11: 12+TURNAROUND+8 cycles.
- Accept-to-cmd_ready latency:
  - ops 00/01/10: 13+GAP cycles.
  - op 11: 21+TURNAROUND+GAP cycles.
- rsp_data holds its value until the next rd-data frame completes. Write/rd-addr frames never touch rsp_data or rsp_valid.
- No protocol ordering enforced: rd-data without a prior rd-addr still runs the full frame and returns whatever MISO carries.
- MISO is ignored outside RECV.
- Reset mid-frame: next cycle SS_n=1, MOSI=0, state=IDLE. No rsp_valid or frame_done is emitted for the aborted frame. rsp_data resets to 0.
- Back-to-back commands: cmd_valid held high re-accepts on the first IDLE cycle. SS_n is guaranteed high for at least GAP+1 cycles (END plus IDLE).
- Counters are 4-bit, saturate-free, and clear on each state entry.

Test Plan:
- Reset: assert rst for 3 cycles mid-SHIFT -> SS_n=1, MOSI=0, busy=0, rsp_data=00 next cycle; cmd_ready=1 after rst drops; no frame_done.
- Write address 0x3C (op 00) -> MOSI sequence over SHIFT = 0,0,0,0,0,1,1,1,1,0,0; SS_n low 12 cycles; frame_done once; rsp_valid never pulses.
- Write data 0xA5 (op 01) to wrapper after wr-addr 0x3C -> RAM[0x3C]==0xA5. MOSI sequence = 0,0,1,1,0,1,0,0,1,0,1.
- Read addr 0x3C then read data (op 11), slave returns 0xA5 -> MISO sampled 1,0,1,0,0,1,0,1; rsp_valid single pulse with rsp_data=0xA5; SS_n low 22 cycles (TURNAROUND=2).
- Back-to-back: cmd_valid held high with ops 00,01,10,11 -> each accepted only in IDLE; SS_n high ≥2 cycles between frames; exactly 4 frame_done pulses and 1 rsp_valid.
- Command while busy: pulse cmd_valid with op 01, data 0xFF mid-frame -> ignored, in-flight MOSI bits unchanged, no extra frame.

Source files
------------

// File: rtl/spi_master_seq_if.sv
// spi_master_seq_if
// Bundles the requester-side command/response signals and the SPI pins of spi_master_seq.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake (op 00 wr-addr, 01 wr-data,
//                                         10 rd-addr, 11 rd-data)
//   rsp_valid/rsp_data                  : one-cycle pulse with the byte captured from MISO
//   frame_done/busy                     : frame end pulse and non-idle status
//   SS_n/MOSI/MISO                      : SPI slave select (active low) and serial data
// master modport is the SPI master block; slave modport is the requester plus SPI slave side.
interface spi_master_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       frame_done;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   modport master (
      input  cmd_valid, cmd_op, cmd_data, MISO,
      output cmd_ready, rsp_valid, rsp_data, frame_done, busy, SS_n, MOSI
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_data, MISO,
      input  cmd_ready, rsp_valid, rsp_data, frame_done, busy, SS_n, MOSI
   );
endinterface

// File: rtl/spi_master_seq.sv
// spi_master_seq
// Command-driven SPI master. Each accepted command becomes one 11-bit frame
// {op[1], op[1:0], data[7:0]} shifted MSB first, one bit per clock. Read-data frames (op 11)
// add a turnaround and an 8-bit MISO capture returned on rsp_data with a rsp_valid pulse.
// Ports:
//   i_clk  : system clock, rising edge
//   i_rst  : synchronous active-high reset
//   io_bus : spi_master_seq_if master modport (command, response, status and SPI pins)
// Parameters:
//   TURNAROUND : cycles between the last MOSI bit and the first MISO sample (1..15)
//   GAP        : END cycles with SS_n high before returning to idle (1..15)
module spi_master_seq #(
   parameter int unsigned TURNAROUND = 2,
   parameter int unsigned GAP        = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   spi_master_seq_if.master io_bus
);

   typedef enum logic [2:0] {StIdle, StStart, StShift, StTurn, StRecv, StEnd} state_e;

   localparam logic [3:0] ShiftLast = 4'd10;
   localparam logic [3:0] TurnLast  = 4'(TURNAROUND - 1);
   localparam logic [3:0] RecvLast  = 4'd7;
   localparam logic [3:0] GapLast   = 4'(GAP - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [10:0] r_sr;
   logic [7:0]  r_rx;
   logic [7:0]  r_rsp_data;
   logic        r_rsp_valid;
   logic        r_op_rd;
   logic        w_accept;
   logic        w_ss_n;
   logic        w_mosi;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ss_n      = 1'b1;
      w_mosi      = 1'b0;
      case (r_state)
         StIdle: begin
            if (io_bus.cmd_valid && !i_rst) begin
               w_accept    = 1'b1;
               w_state_nxt = StStart;
            end
         end
         StStart: begin
            w_ss_n      = 1'b0;
            w_state_nxt = StShift;
         end
         StShift: begin
            w_ss_n = 1'b0;
            w_mosi = r_sr[10];
            if (r_cnt == ShiftLast) begin
               w_state_nxt = r_op_rd ? StTurn : StEnd;
            end
         end
         StTurn: begin
            w_ss_n = 1'b0;
            if (r_cnt == TurnLast) begin
               w_state_nxt = StRecv;
            end
         end
         StRecv: begin
            w_ss_n = 1'b0;
            if (r_cnt == RecvLast) begin
               w_state_nxt = StEnd;
            end
         end
         StEnd: begin
            if (r_cnt == GapLast) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_sr        <= 11'd0;
         r_rx        <= 8'd0;
         r_rsp_data  <= 8'd0;
         r_rsp_valid <= 1'b0;
         r_op_rd     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Counter restarts on every state entry; idle keeps it parked at zero.
         if ((w_state_nxt != r_state) || (r_state == StIdle)) begin
            r_cnt <= 4'd0;
         end else begin
            r_cnt <= r_cnt + 4'd1;
         end

         r_rsp_valid <= 1'b0;

         if (w_accept) begin
            r_sr    <= {io_bus.cmd_op[1], io_bus.cmd_op, io_bus.cmd_data};
            r_op_rd <= &io_bus.cmd_op;
         end else if (r_state == StShift) begin
            r_sr <= {r_sr[9:0], 1'b0};
         end

         if (r_state == StRecv) begin
            r_rx <= {r_rx[6:0], io_bus.MISO};
            // The 8th sample goes straight to rsp_data so the pulse lines up with END entry.
            if (r_cnt == RecvLast) begin
               r_rsp_data  <= {r_rx[6:0], io_bus.MISO};
               r_rsp_valid <= 1'b1;
            end
         end
      end
   end

   assign io_bus.cmd_ready  = (r_state == StIdle) && !i_rst;
   assign io_bus.busy       = (r_state != StIdle);
   assign io_bus.frame_done = (r_state == StEnd) && (r_cnt == 4'd0);
   assign io_bus.rsp_valid  = r_rsp_valid;
   assign io_bus.rsp_data   = r_rsp_data;
   assign io_bus.SS_n       = w_ss_n;
   assign io_bus.MOSI       = w_mosi;

endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq
// Directed bench for spi_master_seq. A frame-offset model predicts every output each cycle
// from acceptance timing; a behavioural SPI slave with a 256-byte RAM decodes MOSI frames
// and answers read-data frames on MISO.
module tb_spi_master_seq;
   localparam int TA  = 2;
   localparam int GP  = 1;
   localparam int RS  = 12 + TA;  // index of first RECV cycle within SS_n-low window

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_master_seq_if bus ();

   spi_master_seq #(
      .TURNAROUND(TA),
      .GAP       (GP)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_bus(bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: outputs as a function of cycles since acceptance ----------------
   int          m_off = 0;       // 0 idle, 1 = START cycle, ...
   int          m_len = 12;      // SS_n-low length of current frame
   logic        m_rd  = 1'b0;
   logic [10:0] m_word = '0;
   logic [7:0]  m_wa = '0, m_ra = '0, m_exp = '0, m_rsp = '0;
   logic [7:0]  m_ram [256] = '{default: 8'h00};
   logic        m_acc = 1'b0;

   always @(posedge clk) begin
      m_acc <= 1'b0;
      if (rst) begin
         m_off <= 0;
         m_rsp <= 8'h00;
      end else if (m_off == 0) begin
         if (bus.cmd_valid) begin
            m_acc  <= 1'b1;
            m_off  <= 1;
            m_word <= {bus.cmd_op[1], bus.cmd_op, bus.cmd_data};
            m_rd   <= (bus.cmd_op == 2'b11);
            m_len  <= (bus.cmd_op == 2'b11) ? 20 + TA : 12;
            m_exp  <= m_ram[m_ra];
         end
      end else begin
         if (m_off == m_len) begin
            case (m_word[9:8])
               2'b00: m_wa <= m_word[7:0];
               2'b01: m_ram[m_wa] <= m_word[7:0];
               2'b10: m_ra <= m_word[7:0];
               default: m_rsp <= m_exp;
            endcase
         end
         m_off <= (m_off == m_len + GP) ? 0 : m_off + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit started = 1'b0;
   always @(negedge clk) begin
      if (started) begin
         check("SS_n", 32'(bus.SS_n), 32'(!(m_off >= 1 && m_off <= m_len)));
         check("MOSI", 32'(bus.MOSI),
               32'((m_off >= 2 && m_off <= 12) ? m_word[12 - m_off] : 1'b0));
         check("busy", 32'(bus.busy), 32'(m_off != 0));
         check("cmd_ready", 32'(bus.cmd_ready), 32'(m_off == 0 && !rst));
         check("frame_done", 32'(bus.frame_done), 32'(m_off == m_len + 1));
         check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rd && m_off == m_len + 1));
         check("rsp_data", 32'(bus.rsp_data), 32'(m_rsp));
      end
   end

   int fd_cnt = 0;
   int rv_cnt = 0;
   always @(negedge clk) begin
      if (bus.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
      if (bus.rsp_valid === 1'b1) rv_cnt <= rv_cnt + 1;
   end

   // ---------------- SPI slave + RAM ----------------
   int          sc = 0, hc = 0, last_low = 0, last_high = 0;
   logic [9:0]  s_sh = '0;
   logic [10:0] last_word = '0;
   logic [7:0]  s_wa = '0, s_ra = '0, s_rep = '0;
   logic [7:0]  s_ram [256] = '{default: 8'h00};

   always @(posedge clk) begin
      if (bus.SS_n == 1'b0) begin
         if (sc == 0) last_high <= hc;
         hc <= 0;
         sc <= sc + 1;
         if (sc >= 1 && sc <= 10) s_sh <= {s_sh[8:0], bus.MOSI};
         if (sc == 11) begin
            last_word <= {s_sh, bus.MOSI};
            case (s_sh[8:7])
               2'b00: s_wa <= {s_sh[6:0], bus.MOSI};
               2'b01: s_ram[s_wa] <= {s_sh[6:0], bus.MOSI};
               2'b10: s_ra <= {s_sh[6:0], bus.MOSI};
               default: s_rep <= s_ram[s_ra];
            endcase
         end
         if (sc + 1 >= RS && sc + 1 <= RS + 7) bus.MISO <= s_rep[7 - (sc + 1 - RS)];
         else bus.MISO <= 1'($urandom_range(0, 1));  // noise outside RECV
      end else begin
         if (sc != 0) last_low <= sc;
         sc <= 0;
         hc <= hc + 1;
         bus.MISO <= 1'($urandom_range(0, 1));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_acc();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (m_acc) break;
      end
      if (!m_acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no accept want accept at %0t", $time);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      wait_acc();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (m_off == 0) break;
      end
      if (m_off != 0) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy want idle at %0t", $time);
      end
   endtask

   logic [1:0] b2b_op [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic [7:0] b2b_d  [4] = '{8'h10, 8'h5A, 8'h10, 8'h00};

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_data  = 8'h00;
      @(posedge clk);
      started = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // write address 0x3C
      issue(2'b00, 8'h3C);
      wait_idle();
      check("wa_word", 32'(last_word), 32'h03C);
      check("wa_low", 32'(last_low), 32'd12);
      check("wa_fd", 32'(fd_cnt), 32'd1);
      check("wa_rv", 32'(rv_cnt), 32'd0);

      // write data 0xA5, with a command poked mid-frame that must be ignored
      issue(2'b01, 8'hA5);
      repeat (4) @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b01;
      bus.cmd_data  = 8'hFF;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      check("wd_word", 32'(last_word), 32'h1A5);
      check("ram_3c", 32'(s_ram[8'h3C]), 32'h0A5);
      check("wd_fd", 32'(fd_cnt), 32'd2);

      // read address 0x3C then read data (payload 0x81 still shifted)
      issue(2'b10, 8'h3C);
      wait_idle();
      issue(2'b11, 8'h81);
      wait_idle();
      check("rd_word", 32'(last_word), 32'h781);
      check("rd_data", 32'(bus.rsp_data), 32'h0A5);
      check("rd_rv", 32'(rv_cnt), 32'd1);
      check("rd_low", 32'(last_low), 32'd22);
      check("rd_fd", 32'(fd_cnt), 32'd4);

      // back-to-back with cmd_valid held high
      bus.cmd_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.cmd_op   = b2b_op[k];
         bus.cmd_data = b2b_d[k];
         wait_acc();
      end
      bus.cmd_valid = 1'b0;
      wait_idle();
      check("b2b_data", 32'(bus.rsp_data), 32'h05A);
      check("b2b_fd", 32'(fd_cnt), 32'd8);
      check("b2b_rv", 32'(rv_cnt), 32'd2);
      check("b2b_gap", 32'(last_high), 32'd2);

      // reset in the middle of SHIFT of a write-data frame
      issue(2'b01, 8'h77);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_data", 32'(bus.rsp_data), 32'h000);
      check("rst_fd", 32'(fd_cnt), 32'd8);
      check("rst_ram", 32'(s_ram[8'h10]), 32'h05A);

      // normal read after reset
      issue(2'b11, 8'h00);
      wait_idle();
      check("post_data", 32'(bus.rsp_data), 32'h05A);
      check("post_rv", 32'(rv_cnt), 32'd3);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
